// File: rtl/bram_arbiter.sv
// Round-robin arbiter merging a fetch requester and a data requester onto one
// single-port bram request/ready interface, one registered transaction at a time.
module bram_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic        bram_valid,
   output logic        bram_instr,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_wdata,
   output logic [3:0]  bram_wstrb,
   input  logic [31:0] bram_rdata,
   input  logic        bram_ready
);
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY_I = 2'b01,
      BUSY_D = 2'b10
   } state_t;

   state_t      state_r, state_s;
   logic        last_instr_r, last_instr_s;
   logic        valid_r, valid_s;
   logic        instr_r, instr_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic [3:0]  wstrb_r, wstrb_s;
   logic        grant_i_s, grant_d_s;

   // Next-state, round-robin arbitration and request capture
   always_comb begin
      state_s      = state_r;
      last_instr_s = last_instr_r;
      valid_s      = valid_r;
      instr_s      = instr_r;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      wstrb_s      = wstrb_r;
      grant_i_s    = 1'b0;
      grant_d_s    = 1'b0;
      case (state_r)
         IDLE: begin
            // On contention the requester that did not win last time goes first
            if (imem_valid && (!dmem_valid || !last_instr_r)) begin
               grant_i_s = 1'b1;
            end else if (dmem_valid) begin
               grant_d_s = 1'b1;
            end else begin
               grant_i_s = 1'b0;
            end
            if (grant_i_s) begin
               state_s      = BUSY_I;
               last_instr_s = 1'b1;
               valid_s      = 1'b1;
               instr_s      = 1'b1;
               addr_s       = imem_addr;
               wdata_s      = 32'h0000_0000;
               wstrb_s      = 4'b0000;
            end else if (grant_d_s) begin
               state_s      = BUSY_D;
               last_instr_s = 1'b0;
               valid_s      = 1'b1;
               instr_s      = 1'b0;
               addr_s       = dmem_addr;
               wdata_s      = dmem_wdata;
               wstrb_s      = dmem_wstrb;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bram_ready) begin
               state_s = IDLE;
               valid_s = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = IDLE;
            valid_s = 1'b0;
         end
      endcase
   end

   // State, round-robin pointer and registered bram request
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         last_instr_r <= 1'b1;
         valid_r      <= 1'b0;
         instr_r      <= 1'b0;
         addr_r       <= 32'h0000_0000;
         wdata_r      <= 32'h0000_0000;
         wstrb_r      <= 4'b0000;
      end else begin
         state_r      <= state_s;
         last_instr_r <= last_instr_s;
         valid_r      <= valid_s;
         instr_r      <= instr_s;
         addr_r       <= addr_s;
         wdata_r      <= wdata_s;
         wstrb_r      <= wstrb_s;
      end
   end

   // Completion forwarding: ready and read data reach only the requester being served
   always_comb begin
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      imem_rdata = 32'h0000_0000;
      dmem_rdata = 32'h0000_0000;
      if (bram_ready && (state_r == BUSY_I)) begin
         imem_ready = 1'b1;
         imem_rdata = bram_rdata;
      end else if (bram_ready && (state_r == BUSY_D)) begin
         dmem_ready = 1'b1;
         dmem_rdata = bram_rdata;
      end else begin
         imem_ready = 1'b0;
         dmem_ready = 1'b0;
      end
   end

   assign bram_valid = valid_r;
   assign bram_instr = instr_r;
   assign bram_addr  = addr_r;
   assign bram_wdata = wdata_r;
   assign bram_wstrb = wstrb_r;
endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: a transaction-level reference predicts grants
// and completions; a memory responder drives bram_ready; a monitor compares.
module tb_bram_arbiter;
   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_valid, dmem_valid;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] imem_rdata, dmem_rdata, bram_addr, bram_wdata, bram_rdata;
   logic        imem_ready, dmem_ready, bram_valid, bram_instr, bram_ready;
   logic [3:0]  bram_wstrb;

   int          checks = 0;
   int          errors = 0;
   int          cyc_cnt = 0;
   int          mem_wait = 0;
   bit          spur_en = 1'b0;
   bit          fix_en = 1'b0;
   logic [31:0] fix_rdata = 32'h0;
   txn_t        exp_q[$];
   logic [31:0] rsp_q[$];
   logic        grant_log[$];
   bit          mdl_busy = 1'b0;
   bit          last_i = 1'b1;

   bram_arbiter dut (
      .clock(clock), .reset(reset),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata), .bram_ready(bram_ready)
   );

   always #5 clock = ~clock;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkt(input string nm, input txn_t act, input txn_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   initial begin : cycle_counter
      forever begin
         @(posedge clock);
         cyc_cnt++;
      end
   end

   // Reference: whenever memory is idle, the round-robin winner is granted; done on bram_ready
   initial begin : ref_model
      txn_t t;
      bit   win_i;
      forever begin
         @(posedge clock);
         if (!reset) begin
            mdl_busy = 1'b0;
            last_i   = 1'b1;
            exp_q.delete();
         end else if (!mdl_busy) begin
            if (imem_valid || dmem_valid) begin
               win_i   = imem_valid && !(dmem_valid && last_i);
               t.instr = win_i;
               t.addr  = win_i ? imem_addr : dmem_addr;
               t.wdata = win_i ? 32'h0 : dmem_wdata;
               t.wstrb = win_i ? 4'h0 : dmem_wstrb;
               exp_q.push_back(t);
               last_i   = win_i;
               mdl_busy = 1'b1;
            end
         end else if (bram_ready) begin
            mdl_busy = 1'b0;
         end
      end
   end

   // Memory responder: ready after mem_wait+1 extra busy cycles, optional spurious idle ready
   initial begin : memory
      int cnt = 0;
      int cur_wait = 0;
      bram_ready = 1'b0;
      bram_rdata = 32'h0;
      forever begin
         @(posedge clock);
         #1;
         bram_rdata = $urandom;
         if (!reset) begin
            bram_ready = 1'b0;
            cnt = 0;
            rsp_q.delete();
         end else if (bram_ready) begin
            bram_ready = 1'b0;
            cnt = 0;
         end else if (bram_valid) begin
            if (cnt == 0) cur_wait = (mem_wait >= 0) ? mem_wait : int'($urandom_range(0, 3));
            if (cnt == cur_wait + 1) begin
               bram_ready = 1'b1;
               bram_rdata = fix_en ? fix_rdata : $urandom;
               rsp_q.push_back(bram_rdata);
            end
            cnt++;
         end else begin
            cnt = 0;
            if (spur_en && ($urandom_range(0, 1) == 1)) bram_ready = 1'b1;
         end
      end
   end

   // Monitor: checks bram request, stability and completion forwarding every cycle
   initial begin : monitor
      bit          prev_v = 1'b0;
      txn_t        cur = '0;
      txn_t        act;
      logic [31:0] rd;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_v = 1'b0;
         end else begin
            chk1("bram_valid", bram_valid, mdl_busy);
            act = {bram_instr, bram_addr, bram_wdata, bram_wstrb};
            if (bram_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  chk1("grant_expected", 1'b1, 1'b0);
               end else begin
                  cur = exp_q.pop_front();
                  grant_log.push_back(cur.instr);
                  if (cur.instr) act.wdata = 32'h0;
                  chkt("grant_req", act, cur);
               end
            end else if (bram_valid) begin
               if (cur.instr) act.wdata = 32'h0;
               chkt("hold_req", act, cur);
            end
            if (bram_valid && bram_ready) begin
               if (rsp_q.size() == 0) begin
                  chk1("rsp_expected", 1'b1, 1'b0);
               end else begin
                  rd = rsp_q.pop_front();
                  chk1("imem_ready", imem_ready, cur.instr);
                  chk1("dmem_ready", dmem_ready, !cur.instr);
                  chk32("imem_rdata", imem_rdata, cur.instr ? rd : 32'h0);
                  chk32("dmem_rdata", dmem_rdata, cur.instr ? 32'h0 : rd);
               end
            end else begin
               chk1("imem_ready_idle", imem_ready, 1'b0);
               chk1("dmem_ready_idle", dmem_ready, 1'b0);
               chk32("imem_rdata_idle", imem_rdata, 32'h0);
               chk32("dmem_rdata_idle", dmem_rdata, 32'h0);
            end
            prev_v = bram_valid;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "simulation time bound exceeded");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // which: 0 fetch, 1 data, 2 either; returns at the negedge of the ready cycle
   task automatic wait_rdy(input int which, output bit got_i, output logic [31:0] rd);
      bit ok = 1'b0;
      got_i = 1'b0;
      rd = 32'h0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clock);
         if (which != 1 && imem_ready) begin
            got_i = 1'b1; rd = imem_rdata; ok = 1'b1;
         end else if (which != 0 && dmem_ready) begin
            got_i = 1'b0; rd = dmem_rdata; ok = 1'b1;
         end
      end
      chk1("ready_timeout", ok, 1'b1);
   endtask

   task automatic step_random(input bit allow_new);
      logic ir, dr;
      @(negedge clock);
      ir = imem_ready;
      dr = dmem_ready;
      @(posedge clock);
      #1;
      if (imem_valid) begin
         if (ir) begin
            imem_valid = allow_new && ($urandom_range(0, 1) == 1);
            imem_addr = $urandom;
         end else if ($urandom_range(0, 3) == 0) begin
            imem_addr = $urandom;
         end
      end else if (allow_new && ($urandom_range(0, 2) == 0)) begin
         imem_valid = 1'b1;
         imem_addr = $urandom;
      end
      if (dmem_valid) begin
         if (dr) begin
            dmem_valid = allow_new && ($urandom_range(0, 1) == 1);
            dmem_addr = $urandom; dmem_wdata = $urandom;
            dmem_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 3) == 0) begin
            dmem_addr = $urandom; dmem_wdata = $urandom; dmem_wstrb = 4'($urandom_range(0, 15));
         end
      end else if (allow_new && ($urandom_range(0, 2) == 0)) begin
         dmem_valid = 1'b1;
         dmem_addr = $urandom; dmem_wdata = $urandom;
         dmem_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      end
   endtask

   initial begin : stimulus
      bit          gi;
      logic [31:0] rd;
      int          times[$];
      int          hits;
      bit          found;
      reset = 1'b1;
      imem_valid = 1'b0; imem_addr = 32'h0;
      dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
      #2 reset = 1'b0;
      cyc(3);
      chk1("rst_bram_valid", bram_valid, 1'b0);
      chk1("rst_bram_instr", bram_instr, 1'b0);
      chk32("rst_bram_addr", bram_addr, 32'h0);
      chk32("rst_bram_wdata", bram_wdata, 32'h0);
      chk32("rst_bram_wstrb", {28'h0, bram_wstrb}, 32'h0);
      chk1("rst_imem_ready", imem_ready, 1'b0);
      chk1("rst_dmem_ready", dmem_ready, 1'b0);
      reset = 1'b1;

      // Single fetch with a fixed read value
      mem_wait = 2; fix_en = 1'b1; fix_rdata = 32'hDEAD_BEEF;
      imem_valid = 1'b1; imem_addr = 32'h0000_0100;
      wait_rdy(0, gi, rd);
      chk32("fetch_rdata", rd, 32'hDEAD_BEEF);
      @(posedge clock); #1;
      imem_valid = 1'b0; fix_en = 1'b0;
      cyc(2);

      // Data write, then the mandatory bubble
      dmem_valid = 1'b1; dmem_addr = 32'h0000_0204; dmem_wdata = 32'h1122_3344; dmem_wstrb = 4'b0101;
      wait_rdy(1, gi, rd);
      @(posedge clock); #1;
      dmem_valid = 1'b0;
      @(negedge clock);
      chk1("bubble_after_write", bram_valid, 1'b0);
      cyc(2);

      // Contention from reset with both requesters held high
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      grant_log.delete();
      mem_wait = 0;
      imem_valid = 1'b1; imem_addr = 32'h0000_1000;
      dmem_valid = 1'b1; dmem_addr = 32'h0000_2000; dmem_wdata = 32'hCAFE_F00D; dmem_wstrb = 4'hF;
      for (int k = 0; k < 4; k++) begin
         wait_rdy(2, gi, rd);
         @(posedge clock); #1;
         if (k == 3) begin
            imem_valid = 1'b0; dmem_valid = 1'b0;
         end else if (gi) begin
            imem_addr = imem_addr + 32'd4;
         end else begin
            dmem_addr = dmem_addr + 32'd4;
         end
      end
      cyc(2);
      chk32("grant_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() >= 4) begin
         for (int k = 0; k < 4; k++) chk1("grant_order", grant_log[k], 1'(k % 2));
      end

      // Back-to-back fetches, zero-wait memory, address churning every cycle
      times.delete();
      imem_valid = 1'b1; imem_addr = 32'h0000_3000;
      for (int n = 0; n < 60 && times.size() < 5; n++) begin
         @(negedge clock);
         if (imem_ready) times.push_back(cyc_cnt);
         @(posedge clock); #1;
         if (times.size() == 5) imem_valid = 1'b0;
         else imem_addr = $urandom & 32'hFFFF_FFFC;
      end
      chk32("b2b_count", 32'(times.size()), 32'd5);
      for (int k = 0; k + 1 < times.size(); k++)
         chk32("b2b_period", 32'(times[k+1] - times[k]), 32'd3);
      cyc(2);

      // Spurious bram_ready while idle
      spur_en = 1'b1;
      hits = 0;
      repeat (16) begin
         @(negedge clock);
         if (imem_ready || dmem_ready || bram_valid) hits++;
      end
      chk32("spurious_effects", 32'(hits), 32'd0);
      spur_en = 1'b0;
      cyc(2);

      // Reset in the middle of a data read; request reissues after release
      mem_wait = 5;
      dmem_valid = 1'b1; dmem_addr = 32'h0000_4008; dmem_wstrb = 4'h0;
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clock);
         found = bram_valid;
      end
      chk1("busy_d_reached", found, 1'b1);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk1("rst_async_valid", bram_valid, 1'b0);
      chk1("rst_async_dready", dmem_ready, 1'b0);
      repeat (3) begin
         @(negedge clock);
         chk1("rst_hold_valid", bram_valid, 1'b0);
         chk1("rst_hold_dready", dmem_ready, 1'b0);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      mem_wait = 1;
      wait_rdy(1, gi, rd);
      @(posedge clock); #1;
      dmem_valid = 1'b0;
      cyc(2);

      // Randomized traffic with random waits and spurious idle readies
      mem_wait = -1;
      spur_en = 1'b1;
      repeat (600) step_random(1'b1);
      for (int n = 0; n < 200 && (imem_valid || dmem_valid); n++) step_random(1'b0);
      chk1("drained", imem_valid || dmem_valid, 1'b0);
      spur_en = 1'b0;
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
